// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter
// Shares one single-port asynchronous frame-buffer SRAM between the display
// scan-out reader and the capture-path writer. Display wins by default, but
// a run counter bounds how many back-to-back display grants can pass a
// pending capture request so the capture path always makes progress.
// Every output is registered. Outputs are computed one cycle ahead from the
// next-state logic and loaded together with the state register.

module fb_sram_arbiter #(
   parameter int AW          = 18,
   parameter int DW          = 16,
   parameter int RD_LAT      = 2,
   parameter int WR_CYC      = 2,
   parameter int MAX_DPY_RUN = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   // display scan-out read port
   input  logic          dpy_req,
   input  logic [AW-1:0] dpy_addr,
   output logic          dpy_ack,
   output logic [DW-1:0] dpy_rdata,
   output logic          dpy_rvalid,
   // capture write port
   input  logic          cap_req,
   input  logic [AW-1:0] cap_addr,
   input  logic [DW-1:0] cap_wdata,
   output logic          cap_ack,
   // SRAM pins
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_oe,
   input  logic [DW-1:0] mem_rdata,
   // status
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      RD_DONE = 2'd2,
      WR      = 2'd3
   } state_t;

   // Phase counters count down to zero; zero marks the last strobe cycle.
   localparam logic [2:0] RD_LOAD   = 3'(RD_LAT - 1);
   localparam logic [2:0] WR_LOAD   = 3'(WR_CYC - 1);
   localparam logic [7:0] RUN_LIMIT = 8'(MAX_DPY_RUN);
   localparam logic [7:0] RUN_SAT   = 8'hFF;

   // Saturating increment for the display run counter.
   function automatic logic [7:0] run_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value == RUN_SAT) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    phase_cnt;
   logic [2:0]    phase_cnt_nxt;
   logic [7:0]    run_cnt;
   logic [7:0]    run_cnt_nxt;

   logic          grant_cap;
   logic          grant_dpy;

   logic          dpy_ack_nxt;
   logic [DW-1:0] dpy_rdata_nxt;
   logic          dpy_rvalid_nxt;
   logic          cap_ack_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic [DW-1:0] mem_wdata_nxt;
   logic          mem_we_nxt;
   logic          mem_oe_nxt;
   logic          busy_nxt;

   // Grant decision: capture wins when display is absent or has used up its run.
   always_comb begin
      grant_cap = 1'b0;
      grant_dpy = 1'b0;
      if (state == IDLE) begin
         if (cap_req && (!dpy_req || (run_cnt == RUN_LIMIT))) begin
            grant_cap = 1'b1;
         end else if (dpy_req) begin
            grant_dpy = 1'b1;
         end else begin
            grant_cap = 1'b0;
            grant_dpy = 1'b0;
         end
      end else begin
         grant_cap = 1'b0;
         grant_dpy = 1'b0;
      end
   end

   // Run counter: counts display grants that passed a waiting capture request.
   always_comb begin
      run_cnt_nxt = run_cnt;
      if (!cap_req) begin
         run_cnt_nxt = 8'd0;
      end else if (grant_cap) begin
         run_cnt_nxt = 8'd0;
      end else if (grant_dpy) begin
         run_cnt_nxt = run_inc(run_cnt);
      end else begin
         run_cnt_nxt = run_cnt;
      end
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_nxt      = state;
      phase_cnt_nxt  = phase_cnt;
      dpy_ack_nxt    = 1'b0;
      dpy_rvalid_nxt = 1'b0;
      cap_ack_nxt    = 1'b0;
      mem_we_nxt     = 1'b0;
      mem_oe_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      dpy_rdata_nxt  = dpy_rdata;

      case (state)
         IDLE: begin
            if (grant_cap) begin
               // Address and data are latched here and held for the whole strobe.
               state_nxt     = WR;
               phase_cnt_nxt = WR_LOAD;
               cap_ack_nxt   = 1'b1;
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = cap_addr;
               mem_wdata_nxt = cap_wdata;
            end else if (grant_dpy) begin
               state_nxt     = RD;
               phase_cnt_nxt = RD_LOAD;
               dpy_ack_nxt   = 1'b1;
               mem_oe_nxt    = 1'b1;
               mem_addr_nxt  = dpy_addr;
            end else begin
               state_nxt = IDLE;
            end
         end

         RD: begin
            if (phase_cnt == 3'd0) begin
               // Last output-enable cycle: SRAM data has settled, capture it.
               state_nxt      = RD_DONE;
               dpy_rdata_nxt  = mem_rdata;
               dpy_rvalid_nxt = 1'b1;
            end else begin
               phase_cnt_nxt = phase_cnt - 3'd1;
               mem_oe_nxt    = 1'b1;
            end
         end

         RD_DONE: begin
            state_nxt = IDLE;
         end

         WR: begin
            if (phase_cnt == 3'd0) begin
               state_nxt = IDLE;
            end else begin
               phase_cnt_nxt = phase_cnt - 3'd1;
               mem_we_nxt    = 1'b1;
            end
         end

         default: begin
            state_nxt     = IDLE;
            phase_cnt_nxt = 3'd0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE) ? 1'b1 : 1'b0;
   end

   // State, counters and registered outputs; reset drops any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         phase_cnt  <= 3'd0;
         run_cnt    <= 8'd0;
         dpy_ack    <= 1'b0;
         dpy_rdata  <= '0;
         dpy_rvalid <= 1'b0;
         cap_ack    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_oe     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase_cnt  <= phase_cnt_nxt;
         run_cnt    <= run_cnt_nxt;
         dpy_ack    <= dpy_ack_nxt;
         dpy_rdata  <= dpy_rdata_nxt;
         dpy_rvalid <= dpy_rvalid_nxt;
         cap_ack    <= cap_ack_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         mem_we     <= mem_we_nxt;
         mem_oe     <= mem_oe_nxt;
         busy       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// tb_fb_sram_arbiter
// Directed bench for the frame-buffer SRAM arbiter: single read, single
// write, sustained contention, run-counter clearing and mid-access resets.
// Expected values are hand-computed from the access timing.

module tb_fb_sram_arbiter;

   localparam int AW = 18;
   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic          dpy_req;
   logic [AW-1:0] dpy_addr;
   logic          dpy_ack;
   logic [DW-1:0] dpy_rdata;
   logic          dpy_rvalid;
   logic          cap_req;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;
   logic          cap_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_oe;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   logic [63:0]   all_outs;
   int            n_checks;
   int            n_fail;

   fb_sram_arbiter #(
      .AW          (AW),
      .DW          (DW),
      .RD_LAT      (2),
      .WR_CYC      (2),
      .MAX_DPY_RUN (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dpy_req    (dpy_req),
      .dpy_addr   (dpy_addr),
      .dpy_ack    (dpy_ack),
      .dpy_rdata  (dpy_rdata),
      .dpy_rvalid (dpy_rvalid),
      .cap_req    (cap_req),
      .cap_addr   (cap_addr),
      .cap_wdata  (cap_wdata),
      .cap_ack    (cap_ack),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_oe     (mem_oe),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   assign all_outs = {8'd0, dpy_ack, dpy_rvalid, cap_ack, mem_we, mem_oe, busy,
                      dpy_rdata, mem_addr, mem_wdata};

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; (i < 20) && busy; i++) begin
         tick();
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   // Hard stop in case something unforeseen stalls the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          g;
      int          overlap;
      logic [26:0] seq;
      int          nd;
      int          nafter;
      bit          got_cap;
      int          nacks;
      int          nrv;

      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      dpy_req   = 1'b0;
      dpy_addr  = '0;
      cap_req   = 1'b0;
      cap_addr  = '0;
      cap_wdata = '0;
      mem_rdata = '0;

      // ---------------- reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", all_outs, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_after_reset", all_outs, 64'd0);

      // ---------------- test 1: single display read (cycle 0 = now)
      dpy_req   = 1'b1;
      dpy_addr  = 18'h00010;
      mem_rdata = 16'hBEEF;
      tick();  // cycle 1
      check("t1_c1_ack", 64'(dpy_ack), 64'd1);
      check("t1_c1_oe", 64'({mem_oe, mem_we}), 64'd2);
      check("t1_c1_addr", 64'(mem_addr), 64'h10);
      check("t1_c1_busy", 64'(busy), 64'd1);
      dpy_req = 1'b0;
      tick();  // cycle 2
      check("t1_c2_ack_oe_rv", 64'({dpy_ack, mem_oe, dpy_rvalid}), 64'b010);
      tick();  // cycle 3
      check("t1_c3_rv_oe", 64'({dpy_rvalid, mem_oe}), 64'b10);
      check("t1_c3_rdata", 64'(dpy_rdata), 64'hBEEF);
      mem_rdata = 16'h0000;
      tick();  // cycle 4
      check("t1_c4_busy_rv", 64'({busy, dpy_rvalid}), 64'd0);
      check("t1_c4_rdata_hold", 64'(dpy_rdata), 64'hBEEF);
      check("t1_c4_addr_hold", 64'(mem_addr), 64'h10);

      // ---------------- test 2: single capture write, then a queued read
      cap_req   = 1'b1;
      cap_addr  = 18'h3FFFF;
      cap_wdata = 16'h1234;
      tick();  // cycle 1
      check("t2_c1_ack", 64'({cap_ack, dpy_ack}), 64'b10);
      check("t2_c1_we_oe", 64'({mem_we, mem_oe}), 64'b10);
      check("t2_c1_addr_data", 64'({mem_addr, mem_wdata}), 64'h3FFFF_1234);
      cap_req  = 1'b0;
      dpy_req  = 1'b1;
      dpy_addr = 18'h00020;
      tick();  // cycle 2
      check("t2_c2_ack", 64'(cap_ack), 64'd0);
      check("t2_c2_we_oe", 64'({mem_we, mem_oe}), 64'b10);
      check("t2_c2_addr_data", 64'({mem_addr, mem_wdata}), 64'h3FFFF_1234);
      tick();  // cycle 3: mandatory IDLE gap
      check("t2_c3_idle", 64'({mem_we, mem_oe, busy, dpy_ack, cap_ack}), 64'd0);
      check("t2_c3_addr_hold", 64'(mem_addr), 64'h3FFFF);
      tick();  // cycle 4: queued display read granted
      check("t2_c4_dpy_ack_oe", 64'({dpy_ack, mem_oe, mem_we}), 64'b110);
      check("t2_c4_addr", 64'(mem_addr), 64'h20);
      dpy_req = 1'b0;
      wait_idle("t2_idle");

      // ---------------- test 3: both requesters held continuously
      seq       = '0;
      g         = 0;
      overlap   = 0;
      dpy_req   = 1'b1;
      dpy_addr  = 18'h00100;
      cap_req   = 1'b1;
      cap_addr  = 18'h00200;
      cap_wdata = 16'h5A5A;
      for (int c = 0; (c < 200) && (g < 27); c++) begin
         tick();
         if (mem_we && mem_oe) begin
            overlap++;
         end
         if (cap_ack) begin
            seq[g] = 1'b1;
            g++;
         end else if (dpy_ack) begin
            g++;
         end
      end
      check("t3_grant_count", 64'(g), 64'd27);
      for (int p = 0; p < 3; p++) begin
         check("t3_period_pattern", 64'(seq[p*9 +: 9]), 64'h100);
      end
      check("t3_we_oe_overlap", 64'(overlap), 64'd0);
      dpy_req = 1'b0;
      cap_req = 1'b0;
      wait_idle("t3_idle");

      // ---------------- test 4: cap_req dropped after 5 display grants
      nd      = 0;
      nafter  = 0;
      got_cap = 1'b0;
      dpy_req = 1'b1;
      cap_req = 1'b1;
      for (int c = 0; (c < 300) && !got_cap; c++) begin
         tick();
         if (cap_ack) begin
            got_cap = 1'b1;
         end else if (dpy_ack) begin
            nd++;
            if (nd == 5) begin
               cap_req = 1'b0;
               tick();
               cap_req = 1'b1;
            end else if (nd > 5) begin
               nafter++;
            end
         end
      end
      check("t4_cap_granted", 64'(got_cap), 64'd1);
      check("t4_dpy_after_drop", 64'(nafter), 64'd8);
      check("t4_dpy_total", 64'(nd), 64'd13);
      dpy_req = 1'b0;
      cap_req = 1'b0;
      wait_idle("t4_idle");

      // ---------------- test 5: reset in the first mem_we cycle
      cap_req   = 1'b1;
      cap_addr  = 18'h01234;
      cap_wdata = 16'hA55A;
      tick();
      check("t5_we_ack_on", 64'({mem_we, cap_ack}), 64'b11);
      cap_req = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_outs_zero", all_outs, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t5_outs_after_release", all_outs, 64'd0);
      nacks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cap_ack || mem_we) begin
            nacks++;
         end
      end
      check("t5_no_further_write", 64'(nacks), 64'd0);

      // ---------------- test 6: reset during a read's mem_oe window
      dpy_req   = 1'b1;
      dpy_addr  = 18'h00055;
      mem_rdata = 16'h1111;
      tick();
      check("t6_ack_oe_on", 64'({dpy_ack, mem_oe}), 64'b11);
      dpy_req = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_oe_off", 64'({mem_oe, dpy_ack}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nrv = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (dpy_rvalid) begin
            nrv++;
         end
      end
      check("t6_no_rvalid", 64'(nrv), 64'd0);
      check("t6_rdata_reset", 64'(dpy_rdata), 64'd0);
      dpy_req   = 1'b1;
      dpy_addr  = 18'h00066;
      mem_rdata = 16'hCAFE;
      tick();
      check("t6_reissue_ack", 64'({dpy_ack, mem_oe}), 64'b11);
      check("t6_reissue_addr", 64'(mem_addr), 64'h66);
      dpy_req = 1'b0;
      tick();
      tick();
      check("t6_reissue_rvalid", 64'(dpy_rvalid), 64'd1);
      check("t6_reissue_rdata", 64'(dpy_rdata), 64'hCAFE);
      wait_idle("t6_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
